display_select_ctrl: RTL
========================

# display_select_ctrl

Generates the `Display_Select` and `Display_Enable` controls consumed by the debug display mux. The operator steps through views 0..NUM_VIEWS-1 with two pushbuttons, or lets the block auto-scroll. Buttons are raw, active-low and bouncy; this block synchronizes and debounces them and turns each accepted press into exactly one select step.

## Interface
Parameters:
- `NUM_VIEWS`, 24: number of valid select codes; the legal range is 0..NUM_VIEWS-1, and NUM_VIEWS is at most 32.
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz).
- `SCROLL_CYCLES`, 50000000: auto-scroll period in clocks (1 s at 50 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `Clock`  in  1  system clock.
- `Resetn`  in  1  asynchronous active-low reset.
- `KEY_Up`  in  1  raw pushbutton, active low; a press advances the select.
- `KEY_Down`  in  1  raw pushbutton, active low; a press retreats the select.
- `Auto_Scroll`  in  1  switch; high enables timed advance.
- `Blank_Switch`  in  1  switch; high blanks the display.
- `Display_Select`  out  5  current view code, registered.
- `Display_Enable`  out  1  registered; 1 = display OFF, 0 = mux drives the display.
- `Select_Changed`  out  1  one-cycle pulse in the cycle `Display_Select` takes a new value.

## Operation
- **Synchronizer.** Each KEY input passes through a 2-flop synchronizer. The first flop resets to 1 (released); the second also resets to 1.
- **Debounce FSM.** There is one FSM per key, each with its own counter. States:
  - RELEASED → CHK_DN when the synchronized value is 0.
  - CHK_DN → PRESSED when the counter reaches DEBOUNCE_CYCLES-1 with the value still 0. Any sample of 1 returns it to RELEASED and clears the counter.
  - PRESSED → CHK_UP when the synchronized value is 1.
  - CHK_UP → RELEASED after DEBOUNCE_CYCLES stable 1 samples. Any sample of 0 returns it to PRESSED.
  - The counter clears on every state change.
- **Press pulse.** A one-cycle registered `press` pulse is raised on the CHK_DN→PRESSED transition only. Holding a key does not repeat.
- **Select update** (priority order):
  1. Up and down pulses in the same cycle: no change, and the scroll timer restarts.
  2. Up pulse: select+1, wrapping NUM_VIEWS-1 → 0.
  3. Down pulse: select-1, wrapping 0 → NUM_VIEWS-1.
  4. Scroll expiry (`Auto_Scroll`=1 and timer = SCROLL_CYCLES-1): select+1 with wrap.
- **Scroll timer.**
  - Counts only while `Auto_Scroll`=1 and holds at 0 while it is 0.
  - Restarts at 0 on expiry and on any accepted press.
  - A press in the same cycle as expiry takes precedence; expiry is discarded.
- **Select_Changed.** Asserted exactly when the registered select value differs from its previous value. This includes a step from 0 → NUM_VIEWS-1, and excludes the simultaneous-press case.
- **Display_Enable.** Equals `Blank_Switch` registered through a 2-flop synchronizer. Blanking never alters select or timer state.
- **Out-of-range guard.** Select must never leave 0..NUM_VIEWS-1. If it does (an SEU, for example), the next update cycle forces it to 0.

## Timing
- **Reset values:** `Display_Select`=0, `Display_Enable`=1, `Select_Changed`=0. All FSMs reset to RELEASED and all counters to 0.
- **Reset is asynchronous at assertion.** Asserting `Resetn` mid-debounce or mid-scroll discards progress immediately. After release, a key already held low is accepted as a new press once debounced.
- **Press latency:** if raw KEY is first sampled low at edge N and stays low, the new `Display_Select` is visible after edge N+DEBOUNCE_CYCLES+3, with `Select_Changed` high for that same cycle.
- **Scroll latency:** with `Auto_Scroll` held high from reset, the select advances every SCROLL_CYCLES clocks exactly.
- **Blank latency:** a `Blank_Switch` change appears on `Display_Enable` after 2 edges.

## Structure
- **Shared package `display_pkg`:**
  - `DISP_NUM_VIEWS` = 24, also used by the mux;
  - the debounce state encoding (RELEASED, CHK_DN, PRESSED, CHK_UP);
  - `DISP_OFF` = 1'b1.
- **Sub-module `key_debounce`:** synchronizer + FSM + counter, with parameter DEBOUNCE_CYCLES and ports `Clock`, `Resetn`, `key_n`, `press`. It is instantiated twice; the top holds the select register and the scroll timer.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SCROLL_CYCLES=8.
- Reset, then a clean KEY_Up press held for 20 clocks → `Display_Select` becomes 1 exactly 7 edges after the press, one `Select_Changed` pulse, and no repeat while held.
- KEY_Up bouncing 0,1,0,0,1 then steady 0 → exactly one increment, timed from the last 1→0 edge.
- Select=23 with an Up press → 0. Select=0 with a Down press → 23. `Select_Changed` pulses in both cases.
- Both keys pressed on the same cycle → select unchanged, no `Select_Changed` pulse.
- `Auto_Scroll`=1 from select 5 → 6 at 8 clocks and 7 at 16. An Up press landing on the expiry cycle → only +1, and the next auto step comes 8 clocks later.
- `Resetn` asserted mid-CHK_DN with select=9 → immediate select 0 and `Display_Enable`=1. `Blank_Switch` toggles → `Display_Enable` follows 2 edges later.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the debug display path: view count, debounce
// state encoding, blanking polarity and select wrap helpers.
package display_pkg;

  localparam int DISP_NUM_VIEWS = 24;
  localparam int DISP_SEL_W     = 5;
  localparam logic DISP_OFF     = 1'b1;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    CHK_DN   = 2'd1,
    PRESSED  = 2'd2,
    CHK_UP   = 2'd3
  } db_state_t;

  // Wrapping step helpers; num_views is the count of legal codes.
  function automatic logic [DISP_SEL_W-1:0] sel_inc(input logic [DISP_SEL_W-1:0] sel,
                                                    input int num_views);
    logic [DISP_SEL_W-1:0] last;
    last = DISP_SEL_W'(num_views - 1);
    return (sel == last) ? '0 : sel + DISP_SEL_W'(1);
  endfunction

  function automatic logic [DISP_SEL_W-1:0] sel_dec(input logic [DISP_SEL_W-1:0] sel,
                                                    input int num_views);
    return (sel == '0) ? DISP_SEL_W'(num_views - 1) : sel - DISP_SEL_W'(1);
  endfunction

endpackage

// File: rtl/display_select_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchronizer, four-state debounce FSM with its
// own counter, and a single-cycle press pulse on each accepted press.
module key_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg, sync2_reg;
  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             press_reg, press_next;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
    end
  end

  // Counter only advances inside the two checking states and is zero elsewhere,
  // so every state change leaves it cleared.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    press_next = 1'b0;
    case (state_reg)
      RELEASED: if (!sync2_reg) state_next = CHK_DN;
      CHK_DN: begin
        if (sync2_reg) begin
          state_next = RELEASED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PRESSED: if (sync2_reg) state_next = CHK_UP;
      CHK_UP: begin
        if (!sync2_reg) begin
          state_next = PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  assign press = press_reg;

endmodule

// File: rtl/display_select_ctrl.sv
// Display view selector: debounced up/down keys, optional auto-scroll timer,
// and a synchronized blanking control for the debug display mux.
module display_select_ctrl
  import display_pkg::*;
#(
  parameter int NUM_VIEWS       = DISP_NUM_VIEWS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  KEY_Up,
  input  logic                  KEY_Down,
  input  logic                  Auto_Scroll,
  input  logic                  Blank_Switch,
  output logic [DISP_SEL_W-1:0] Display_Select,
  output logic                  Display_Enable,
  output logic                  Select_Changed
);

  localparam int TMR_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(SCROLL_CYCLES - 1);
  localparam logic [DISP_SEL_W-1:0] SEL_LAST = DISP_SEL_W'(NUM_VIEWS - 1);

  logic [1:0] key_n_vec, press_vec;
  logic       up_press, down_press, expiry;

  logic [DISP_SEL_W-1:0] sel_reg, sel_next;
  logic [TMR_W-1:0]      tmr_reg, tmr_next;
  logic                  changed_reg, changed_next;
  logic                  blank_sync1_reg, blank_sync2_reg;

  // Index 0 is the Up key, index 1 the Down key.
  assign key_n_vec = {KEY_Down, KEY_Up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .Clock (Clock),
        .Resetn(Resetn),
        .key_n (key_n_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  assign up_press   = press_vec[0];
  assign down_press = press_vec[1];

  always_comb begin
    sel_next = sel_reg;
    tmr_next = tmr_reg;
    expiry   = Auto_Scroll && (tmr_reg == TMR_LAST);

    // Any accepted press restarts the timer and swallows a coincident expiry.
    if (up_press || down_press) begin
      tmr_next = '0;
    end else if (!Auto_Scroll || expiry) begin
      tmr_next = '0;
    end else begin
      tmr_next = tmr_reg + TMR_W'(1);
    end

    if (sel_reg > SEL_LAST) begin
      sel_next = '0;
    end else if (up_press && down_press) begin
      sel_next = sel_reg;
    end else if (up_press) begin
      sel_next = sel_inc(sel_reg, NUM_VIEWS);
    end else if (down_press) begin
      sel_next = sel_dec(sel_reg, NUM_VIEWS);
    end else if (expiry) begin
      sel_next = sel_inc(sel_reg, NUM_VIEWS);
    end

    changed_next = (sel_next != sel_reg);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel_reg         <= '0;
      tmr_reg         <= '0;
      changed_reg     <= 1'b0;
      blank_sync1_reg <= DISP_OFF;
      blank_sync2_reg <= DISP_OFF;
    end else begin
      sel_reg         <= sel_next;
      tmr_reg         <= tmr_next;
      changed_reg     <= changed_next;
      blank_sync1_reg <= Blank_Switch;
      blank_sync2_reg <= blank_sync1_reg;
    end
  end

  assign Display_Select = sel_reg;
  assign Display_Enable = blank_sync2_reg;
  assign Select_Changed = changed_reg;

endmodule
